vend_dispense_module: RTL
=========================

# vend_dispense_module

Customer-facing sale engine of the vending machine: it owns the per-product stock counters, accumulates inserted coin credit, and executes purchase requests. It decrements stock, dispenses, and returns change. It is the consuming end of the stock interface whose producing end is the operator restock (charge) path, which it also accepts here. A single FSM serialises restock, purchase and error reporting so that stock and credit are never updated by two operations at once.

## Interface
- PRICE0..PRICE4, default 4'd3, 4'd5, 4'd2, 4'd7, 4'd4: unit price of products 0–4.
- INIT_STOCK, default 4'd0: stock value of every product after reset.
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- coin_valid  in  1  coin inserted this cycle
- coin_value  in  4  coin value
- select_valid  in  1  purchase request
- select_code  in  3  product code (valid 0–4)
- select_count  in  4  items requested
- charge_valid  in  1  restock request
- charge_code  in  3  product code (valid 0–4)
- charge_count  in  4  items to add
- busy  out  1  high whenever FSM is not IDLE
- dispense_valid  out  1  one-cycle dispense pulse
- dispense_code  out  3  product dispensed
- dispense_count  out  4  items dispensed
- change_valid  out  1  one-cycle change pulse
- change_amount  out  8  credit returned
- charge_done  out  1  one-cycle restock-accepted pulse
- error  out  1  one-cycle error pulse
- error_code  out  2  01 invalid code/zero count, 10 stock range, 11 insufficient credit
- credit  out  8  current credit
- sales_total  out  16  cumulative items sold (see Configuration)

## Operation
- States: IDLE, CHECK, CHARGE, DISPENSE, CHANGE, ERROR.
- IDLE:
  - The FSM accepts requests only in IDLE; while busy, select_valid and charge_valid are ignored.
  - Priority: charge_valid over select_valid.
  - A request is latched into internal registers on acceptance.
- Coins:
  - Accepted only in IDLE, including the same cycle as an accepted request.
  - credit <= credit + coin_value, saturating at 255; any excess is lost.
- Restock path: IDLE -> CHARGE -> IDLE.
  - CHARGE, code > 4 or count == 0: go to ERROR with code 01.
  - CHARGE, stock + count > 15: go to ERROR with code 10; stock unchanged.
  - Otherwise stock += count and charge_done pulses.
- Purchase path: IDLE -> CHECK.
  - CHECK computes cost = price × count as 8 bits (max 225).
  - Invalid code or count 0: go to ERROR with code 01.
  - count > stock: go to ERROR with code 10.
  - cost > credit: go to ERROR with code 11.
  - Otherwise go to DISPENSE.
- DISPENSE: stock -= count, credit -= cost, dispense_valid pulses with the latched code and count -> CHANGE.
- CHANGE:
  - change_amount <= remaining credit, change_valid = 1, credit <= 0, then return to IDLE.
  - The change pulse is issued even when the remaining credit is 0.
- ERROR: error pulses for one cycle, credit is retained, then return to IDLE.

## Timing
- Reset (synchronous, one edge with reset = 1):
  - state = IDLE, credit = 0, all stocks = INIT_STOCK, sales_total = 0.
  - All pulse outputs = 0, change_amount = 0, error_code = 00, dispense_code/count = 0.
- Reset mid-operation aborts the operation. No pulse follows, and credit and stock revert to reset values.
- Request accepted at edge E0:
  - Restock: charge_done or error is high in the cycle after E1.
  - Purchase: error (if any) is high in the cycle after E1. dispense_valid is high in the cycle after E1. change_valid is high in the cycle after E2.
- Pulse outputs are registered, each exactly one cycle wide. error_code, dispense_code/count and change_amount hold their value until the next pulse of the same kind.
- busy rises the cycle after acceptance and falls when the FSM re-enters IDLE. A new request can be accepted on the first IDLE edge.

## Configuration
- VEND_SALES_LOG_EN defined:
  - sales_total += dispense_count on every DISPENSE.
  - The counter wraps modulo 2^16.
- Undefined:
  - The counter is not built; sales_total is constant 0.
  - All other behaviour is identical.

## Test plan
- Reset, charge code 1 count 10 -> charge_done 2 cycles later; stock1 = 10; charge code 1 count 6 -> error, error_code 10, stock1 stays 10.
- Coins 4 + 4 + 4 (credit 12), select code 1 count 2 (cost 10) -> dispense_valid code 1 count 2, then change_valid amount 2; credit 0; stock1 = 8.
- Credit 9, select code 1 count 2 -> error code 11 two cycles after select, credit stays 9, no dispense.
- Select code 5, and separately count 0 -> error code 01; select code 0 with stock0 = 0 -> error code 10.
- Credit 250 + coin 15 -> credit 255; charge_valid and select_valid in the same IDLE cycle -> restock executed, select ignored.
- Assert reset during DISPENSE -> next cycle outputs zero, credit 0, stocks = INIT_STOCK; with VEND_SALES_LOG_EN, sales_total counts only completed dispenses.

Source files
------------

// File: rtl/vend_dispense_if.sv
// Handshake bundle between the vending front end and vend_dispense_module.
// master drives coin/purchase/restock requests, slave returns sale results.
interface vend_dispense_if;
    logic        coin_valid;
    logic [3:0]  coin_value;
    logic        select_valid;
    logic [2:0]  select_code;
    logic [3:0]  select_count;
    logic        charge_valid;
    logic [2:0]  charge_code;
    logic [3:0]  charge_count;
    logic        busy;
    logic        dispense_valid;
    logic [2:0]  dispense_code;
    logic [3:0]  dispense_count;
    logic        change_valid;
    logic [7:0]  change_amount;
    logic        charge_done;
    logic        error;
    logic [1:0]  error_code;
    logic [7:0]  credit;
    logic [15:0] sales_total;

    modport master (
        output coin_valid, coin_value, select_valid, select_code, select_count,
               charge_valid, charge_code, charge_count,
        input  busy, dispense_valid, dispense_code, dispense_count, change_valid,
               change_amount, charge_done, error, error_code, credit, sales_total
    );

    modport slave (
        input  coin_valid, coin_value, select_valid, select_code, select_count,
               charge_valid, charge_code, charge_count,
        output busy, dispense_valid, dispense_code, dispense_count, change_valid,
               change_amount, charge_done, error, error_code, credit, sales_total
    );
endinterface

// File: rtl/vend_dispense_module.sv
// Vending sale engine: stock counters, coin credit, restock and purchase FSM.
// Define VEND_SALES_LOG_EN to build the cumulative sales_total counter.
module vend_dispense_module #(
    parameter logic [3:0] PRICE0     = 4'd3,
    parameter logic [3:0] PRICE1     = 4'd5,
    parameter logic [3:0] PRICE2     = 4'd2,
    parameter logic [3:0] PRICE3     = 4'd7,
    parameter logic [3:0] PRICE4     = 4'd4,
    parameter logic [3:0] INIT_STOCK = 4'd0
) (
    input logic            clock_i,
    input logic            reset_i,
    vend_dispense_if.slave bus_io
);
    typedef enum logic [2:0] {
        StIdle, StCheck, StCharge, StDispense, StChange, StError
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  stock_q [5];
    logic [3:0]  stock_d [5];
    logic [7:0]  credit_q, credit_d;
    logic [2:0]  req_code_q, req_code_d;
    logic [3:0]  req_count_q, req_count_d;
    logic        dispense_valid_q, dispense_valid_d;
    logic [2:0]  dispense_code_q, dispense_code_d;
    logic [3:0]  dispense_count_q, dispense_count_d;
    logic        change_valid_q, change_valid_d;
    logic [7:0]  change_amount_q, change_amount_d;
    logic        charge_done_q, charge_done_d;
    logic        error_q, error_d;
    logic [1:0]  error_code_q, error_code_d;

    logic [3:0]  price, stock_cur;
    logic        code_ok;
    logic [7:0]  cost;
    logic [4:0]  charge_sum;
    logic [8:0]  coin_sum;
    logic [1:0]  fault_code;

    always_comb begin
        price     = '0;
        stock_cur = '0;
        code_ok   = 1'b1;
        case (req_code_q)
            3'd0:    begin price = PRICE0; stock_cur = stock_q[0]; end
            3'd1:    begin price = PRICE1; stock_cur = stock_q[1]; end
            3'd2:    begin price = PRICE2; stock_cur = stock_q[2]; end
            3'd3:    begin price = PRICE3; stock_cur = stock_q[3]; end
            3'd4:    begin price = PRICE4; stock_cur = stock_q[4]; end
            default: code_ok = 1'b0;
        endcase
    end

    assign cost       = {4'd0, price} * {4'd0, req_count_q};
    assign charge_sum = {1'b0, stock_cur} + {1'b0, req_count_q};
    assign coin_sum   = {1'b0, credit_q} + {5'd0, bus_io.coin_value};

    // Non-zero fault_code means the operation in CHARGE/CHECK must divert to ERROR.
    always_comb begin
        fault_code = 2'b00;
        case (state_q)
            StCharge: begin
                if (!code_ok || req_count_q == 4'd0) fault_code = 2'b01;
                else if (charge_sum > 5'd15)         fault_code = 2'b10;
            end
            StCheck: begin
                if (!code_ok || req_count_q == 4'd0) fault_code = 2'b01;
                else if (req_count_q > stock_cur)    fault_code = 2'b10;
                else if (cost > credit_q)            fault_code = 2'b11;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus_io.charge_valid)      state_d = StCharge;
                else if (bus_io.select_valid) state_d = StCheck;
            end
            StCharge:   state_d = (fault_code != 2'b00) ? StError : StIdle;
            StCheck:    state_d = (fault_code != 2'b00) ? StError : StDispense;
            StDispense: state_d = StChange;
            StChange:   state_d = StIdle;
            StError:    state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Pulses and stock/credit updates are registered on entry to the state that owns them.
    always_comb begin
        stock_d          = stock_q;
        credit_d         = credit_q;
        req_code_d       = req_code_q;
        req_count_d      = req_count_q;
        dispense_valid_d = 1'b0;
        dispense_code_d  = dispense_code_q;
        dispense_count_d = dispense_count_q;
        change_valid_d   = 1'b0;
        change_amount_d  = change_amount_q;
        charge_done_d    = 1'b0;
        error_d          = 1'b0;
        error_code_d     = error_code_q;
        case (state_q)
            StIdle: begin
                if (bus_io.coin_valid) credit_d = coin_sum[8] ? 8'hFF : coin_sum[7:0];
                if (bus_io.charge_valid) begin
                    req_code_d  = bus_io.charge_code;
                    req_count_d = bus_io.charge_count;
                end else if (bus_io.select_valid) begin
                    req_code_d  = bus_io.select_code;
                    req_count_d = bus_io.select_count;
                end
            end
            StCharge, StCheck: begin
                if (fault_code != 2'b00) begin
                    error_d      = 1'b1;
                    error_code_d = fault_code;
                end else if (state_q == StCharge) begin
                    for (int i = 0; i < 5; i++) begin
                        if (req_code_q == 3'(i)) stock_d[i] = charge_sum[3:0];
                    end
                    charge_done_d = 1'b1;
                end else begin
                    for (int i = 0; i < 5; i++) begin
                        if (req_code_q == 3'(i)) stock_d[i] = stock_cur - req_count_q;
                    end
                    credit_d         = credit_q - cost;
                    dispense_valid_d = 1'b1;
                    dispense_code_d  = req_code_q;
                    dispense_count_d = req_count_q;
                end
            end
            StDispense: begin
                change_valid_d  = 1'b1;
                change_amount_d = credit_q;
                credit_d        = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < 5; i++) stock_q[i] <= INIT_STOCK;
            credit_q         <= '0;
            req_code_q       <= '0;
            req_count_q      <= '0;
            dispense_valid_q <= 1'b0;
            dispense_code_q  <= '0;
            dispense_count_q <= '0;
            change_valid_q   <= 1'b0;
            change_amount_q  <= '0;
            charge_done_q    <= 1'b0;
            error_q          <= 1'b0;
            error_code_q     <= '0;
        end else begin
            stock_q          <= stock_d;
            credit_q         <= credit_d;
            req_code_q       <= req_code_d;
            req_count_q      <= req_count_d;
            dispense_valid_q <= dispense_valid_d;
            dispense_code_q  <= dispense_code_d;
            dispense_count_q <= dispense_count_d;
            change_valid_q   <= change_valid_d;
            change_amount_q  <= change_amount_d;
            charge_done_q    <= charge_done_d;
            error_q          <= error_d;
            error_code_q     <= error_code_d;
        end
    end

`ifdef VEND_SALES_LOG_EN
    logic [15:0] sales_q, sales_d;

    always_comb begin
        sales_d = sales_q;
        if (dispense_valid_d) sales_d = sales_q + {12'd0, dispense_count_d};
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) sales_q <= '0;
        else         sales_q <= sales_d;
    end

    assign bus_io.sales_total = sales_q;
`else
    assign bus_io.sales_total = '0;
`endif

    assign bus_io.busy           = (state_q != StIdle);
    assign bus_io.dispense_valid = dispense_valid_q;
    assign bus_io.dispense_code  = dispense_code_q;
    assign bus_io.dispense_count = dispense_count_q;
    assign bus_io.change_valid   = change_valid_q;
    assign bus_io.change_amount  = change_amount_q;
    assign bus_io.charge_done    = charge_done_q;
    assign bus_io.error          = error_q;
    assign bus_io.error_code     = error_code_q;
    assign bus_io.credit         = credit_q;
endmodule
